// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and constants for the systolic DSP array.
//   W_DEF          default result width of a DSP cell
//   SAT_POS/NEG    saturation limits produced by the cells
//   drain_state_t  state encoding of the result drain FSM
package systolic_pkg;

   localparam int W_DEF = 16;

   localparam logic [15:0] SAT_POS = 16'h7fff;
   localparam logic [15:0] SAT_NEG = 16'h8000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } drain_state_t;

endpackage

// File: rtl/dsp_result_drain.sv
// dsp_result_drain: captures one DSP row's results on cap and streams them out over valid/ready.
//   clk, rst_n     clock, asynchronous active-low reset
//   cap            row clear strobe (same pulse as the cells' sreset)
//   s_in, sat_in   packed cell results (cell k at [k*W +: W]) and saturation flags
//   ovr_clr        clears overrun (and sat_cnt when enabled)
//   out_valid/out_ready/out_data/out_sat/out_idx/out_last   result stream
//   busy           FSM not idle
//   overrun        sticky, a cap arrived while busy and was dropped
//   sat_cnt        saturated words handed out; live only with DSP_DRAIN_SAT_CNT_EN defined
module dsp_result_drain
   import systolic_pkg::*;
#(
   parameter int N = 4,
   parameter int W = W_DEF
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cap,
   input  logic [N*W-1:0]       s_in,
   input  logic [N-1:0]         sat_in,
   input  logic                 ovr_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic                 out_sat,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic                 overrun,
   output logic [7:0]           sat_cnt
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   drain_state_t   state_q, state_d;
   logic [IW-1:0]  idx_q;
   logic [W-1:0]   data_q [N];
   logic [N-1:0]   sat_q;
   logic           ovr_q;
   logic           hs, fin, drop;

   assign hs  = out_valid & out_ready;
   assign fin = hs & (idx_q == LAST);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   // A cap coinciding with the final handshake starts the next tile instead of being dropped.
   always_comb begin
      state_d = state_q;
      drop    = 1'b0;
      case (state_q)
         IDLE:    state_d = cap ? LOAD : IDLE;
         LOAD: begin
            state_d = DRAIN;
            drop    = cap;
         end
         DRAIN: begin
            state_d = fin ? (cap ? LOAD : IDLE) : DRAIN;
            drop    = cap & ~fin;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                idx_q <= '0;
      else if (state_q == LOAD)  idx_q <= '0;
      else if (hs)               idx_q <= fin ? '0 : idx_q + IW'(1);

   // Cell outputs settle one edge after sreset, so the bank is written at the end of LOAD.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int k = 0; k < N; k++) data_q[k] <= '0;
         sat_q <= '0;
      end else if (state_q == LOAD) begin
         for (int k = 0; k < N; k++) data_q[k] <= s_in[k*W +: W];
         sat_q <= sat_in;
      end

   // Setting has priority over clearing.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)       ovr_q <= 1'b0;
      else if (drop)    ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;

   assign out_valid = (state_q == DRAIN);
   assign busy      = (state_q != IDLE);
   assign out_idx   = idx_q;
   assign out_data  = out_valid ? data_q[idx_q] : '0;
   assign out_sat   = out_valid & sat_q[idx_q];
   assign out_last  = out_valid & (idx_q == LAST);
   assign overrun   = ovr_q;

`ifdef DSP_DRAIN_SAT_CNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                              cnt_q <= 8'd0;
      else if (ovr_clr)                        cnt_q <= 8'd0;
      else if (hs & out_sat & (cnt_q != 8'hff)) cnt_q <= cnt_q + 8'd1;

   assign sat_cnt = cnt_q;
`else
   assign sat_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dsp_result_drain.sv
// tb_dsp_result_drain: scoreboard bench for dsp_result_drain (N=4, W=16).
module tb_dsp_result_drain;
   import systolic_pkg::*;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cap = 1'b0;
   logic [N*W-1:0] s_in = '0;
   logic [N-1:0]   sat_in = '0;
   logic           ovr_clr = 1'b0;
   logic           out_ready = 1'b1;
   logic           out_valid, out_sat, out_last, busy, overrun;
   logic [W-1:0]   out_data;
   logic [1:0]     out_idx;
   logic [7:0]     sat_cnt;

   dsp_result_drain #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .cap(cap), .s_in(s_in), .sat_in(sat_in),
      .ovr_clr(ovr_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat), .out_idx(out_idx),
      .out_last(out_last), .busy(busy), .overrun(overrun), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic         s;
      logic [1:0]   i;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: score any handshake on the falling edge, return just after the rising edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (out_valid && out_ready) begin
         check("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("data", out_data, e.d);
            check("sat", out_sat, e.s);
            check("idx", out_idx, e.i);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input logic [N*W-1:0] v, input logic [N-1:0] s);
      for (int k = 0; k < N; k++) sb.push_back('{d: v[k*W +: W], s: s[k], i: 2'(k)});
   endtask

   // Drives cap for one cycle; returns in the LOAD cycle with s_in still held.
   task automatic do_cap(input logic [N*W-1:0] v, input logic [N-1:0] s);
      cap = 1'b1;
      s_in = v;
      sat_in = s;
      push(v, s);
      step();
      cap = 1'b0;
   endtask

   task automatic scramble();
      s_in = {$urandom, $urandom};
      sat_in = 4'($urandom);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin
         step();
         n++;
      end
      check("idle_timeout", busy, 0);
      check("sb_drained", sb.size(), 0);
   endtask

   // Full drain with out_ready high, checking cycle-exact timing.
   task automatic drain(input logic [N*W-1:0] v, input logic [N-1:0] s);
      int t0 = cyc;
      do_cap(v, s);
      check("load_busy", busy, 1);
      check("load_valid", out_valid, 0);
      step();
      scramble();
      for (int k = 0; k < N; k++) begin
         check("drn_cyc", cyc - t0, 2 + k);
         check("drn_valid", out_valid, 1);
         check("drn_idx", out_idx, k);
         check("drn_last", out_last, k == N - 1);
         step();
      end
      check("end_busy", busy, 0);
      check("end_valid", out_valid, 0);
      check("end_last", out_last, 0);
   endtask

   initial begin
      logic [N*W-1:0] v;
      #1 check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_sat", out_sat, 0);
      check("rst_idx", out_idx, 0);
      check("rst_last", out_last, 0);
      check("rst_ovr", overrun, 0);
      check("rst_satcnt", sat_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
      while (cyc < 10) step();

      // single drain, cap in cycle 10
      drain({16'h0004, 16'h0003, 16'hfffe, 16'h0001}, 4'b0000);
      check("t1_cyc", cyc, 16);
      check("t1_ovr", overrun, 0);

      // saturation flags and extremes pass through unmodified
      drain({SAT_NEG, 16'h1234, 16'hfedc, SAT_POS}, 4'b1001);
`ifdef DSP_DRAIN_SAT_CNT_EN
      check("satcnt", sat_cnt, 2);
`else
      check("satcnt", sat_cnt, 0);
`endif
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      check("satcnt_clr", sat_cnt, 0);

      // backpressure at idx 1
      v = {16'h0d0d, 16'h0c0c, 16'h0b0b, 16'h0a0a};
      do_cap(v, 4'b0010);
      step();
      scramble();
      step();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("bp_valid", out_valid, 1);
         check("bp_idx", out_idx, 1);
         check("bp_data", out_data, v[W +: W]);
         check("bp_sat", out_sat, 1);
         step();
      end
      out_ready = 1'b1;
      wait_idle(10);

      // overrun: second cap two cycles later, with ovr_clr in the same cycle (set wins)
      do_cap({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b0100);
      step();
      cap = 1'b1;
      ovr_clr = 1'b1;
      scramble();
      step();
      cap = 1'b0;
      ovr_clr = 1'b0;
      check("ovr_set", overrun, 1);
      wait_idle(10);
      check("ovr_sticky", overrun, 1);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      check("ovr_clr", overrun, 0);

      // back-to-back: next cap on the idx-3 handshake
      do_cap({16'h8001, 16'h7ffe, 16'h0100, 16'h00ff}, 4'b0000);
      step();
      scramble();
      for (int k = 0; k < 3; k++) step();
      check("b2b_last", out_last, 1);
      cap = 1'b1;
      s_in = {16'h5555, 16'haaaa, 16'h0f0f, 16'hf0f0};
      sat_in = 4'b1000;
      push(s_in, sat_in);
      step();
      cap = 1'b0;
      check("b2b_ovr", overrun, 0);
      check("b2b_load_busy", busy, 1);
      check("b2b_load_valid", out_valid, 0);
      step();
      scramble();
      check("b2b_valid", out_valid, 1);
      check("b2b_idx", out_idx, 0);
      wait_idle(10);

      // reset mid-drain at idx 2
      do_cap({16'h0dea, 16'h0bee, 16'h0cab, 16'h0fad}, 4'b1111);
      step();
      scramble();
      step();
      step();
      check("mid_idx", out_idx, 2);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", out_valid, 0);
      check("ar_data", out_data, 0);
      check("ar_sat", out_sat, 0);
      check("ar_idx", out_idx, 0);
      check("ar_last", out_last, 0);
      check("ar_busy", busy, 0);
      check("ar_satcnt", sat_cnt, 0);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("post_rst_busy", busy, 0);
      drain({16'h0321, 16'h0654, 16'h0987, 16'h0cba}, 4'b0001);
      check("final_ovr", overrun, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
